// File: rtl/icache_nway_if.sv
// Fetch-side and memory-side signals of the n-way instruction cache.
// The cache uses the slave view; the fetch stage / memory model use the master view.
interface icache_nway_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        flush;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        busy;

  modport slave (
    input  imemREN, imemaddr, flush, iwait, iload,
    output ihit, imemload, iREN, iaddr, busy
  );

  modport master (
    output imemREN, imemaddr, flush, iwait, iload,
    input  ihit, imemload, iREN, iaddr, busy
  );
endinterface

// File: rtl/icache_nway.sv
// Set-associative instruction cache with per-set round-robin replacement,
// multi-word block fill and a single-cycle synchronous flush.
module icache_nway #(
  parameter int WAYS  = 2,
  parameter int IDX_W = 4,
  parameter int BLK_W = 1,
  parameter int TAG_W = 32 - IDX_W - BLK_W - 2
) (
  input  logic          CLK,
  input  logic          nRST,
  icache_nway_if.slave  bus
);

  localparam int SETS  = 1 << IDX_W;
  localparam int WORDS = 1 << BLK_W;
  localparam int WB    = $clog2(WAYS);
  localparam int WBV   = (WB > 0) ? WB : 1;
  localparam int CW    = (BLK_W > 0) ? BLK_W : 1;
  localparam int LAW   = IDX_W + WB;
  localparam int LINES = SETS * WAYS;
  localparam int DAW   = LAW + BLK_W;
  localparam int DEPTH = LINES * WORDS;

  typedef enum logic {IDLE, FILL} state_t;

  state_t            state_reg;
  logic [TAG_W-1:0]  ltag_reg;
  logic [IDX_W-1:0]  lidx_reg;
  logic [CW-1:0]     cnt_reg;
  logic [WBV-1:0]    vic_reg;
  logic              use_ptr_reg;
  logic              ren_reg;
  logic              busy_reg;
  logic [LINES-1:0]  valid_reg;
  logic [WBV-1:0]    ptr_reg [SETS];

  // Tags and data need a same-cycle read for the combinational hit path.
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [31:0]       data_mem [DEPTH];

  function automatic logic [LAW-1:0] line_index(int set, int way);
    return LAW'(set * WAYS + way);
  endfunction

  function automatic logic [DAW-1:0] word_index(int set, int way, int word);
    return DAW'((set * WAYS + way) * WORDS + word);
  endfunction

  logic [TAG_W-1:0] req_tag;
  int               req_idx;
  int               req_blk;

  assign req_tag = TAG_W'(bus.imemaddr >> (32 - TAG_W));
  assign req_idx = int'((bus.imemaddr >> (2 + BLK_W)) & 32'(SETS - 1));
  assign req_blk = int'((bus.imemaddr >> 2) & 32'(WORDS - 1));

  logic hit;
  int   hit_way;
  logic free_found;
  int   free_way;

  always_comb begin
    hit        = 1'b0;
    hit_way    = 0;
    free_found = 1'b0;
    free_way   = 0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_reg[line_index(req_idx, w)] &&
          tag_mem[line_index(req_idx, w)] == req_tag) begin
        hit     = 1'b1;
        hit_way = w;
      end
      if (!valid_reg[line_index(req_idx, w)] && !free_found) begin
        free_found = 1'b1;
        free_way   = w;
      end
    end
  end

  logic [WBV-1:0] vic_next;
  assign vic_next = free_found ? WBV'(free_way) : ptr_reg[IDX_W'(req_idx)];

  logic [31:0] fill_addr;
  logic        last_word;

  assign fill_addr = (32'(ltag_reg) << (32 - TAG_W)) |
                     (32'(lidx_reg) << (2 + BLK_W)) |
                     (32'(cnt_reg) << 2);
  assign last_word = (cnt_reg == CW'(WORDS - 1));

  assign bus.ihit     = (state_reg == IDLE) && bus.imemREN && hit && !bus.flush;
  assign bus.imemload = bus.ihit ? data_mem[word_index(req_idx, hit_way, req_blk)] : 32'h0;
  assign bus.iREN     = ren_reg;
  assign bus.busy     = busy_reg;
  assign bus.iaddr    = busy_reg ? fill_addr : 32'h0;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg   <= IDLE;
      ltag_reg    <= '0;
      lidx_reg    <= '0;
      cnt_reg     <= '0;
      vic_reg     <= '0;
      use_ptr_reg <= 1'b0;
      ren_reg     <= 1'b0;
      busy_reg    <= 1'b0;
      valid_reg   <= '0;
      for (int s = 0; s < SETS; s++) ptr_reg[s] <= '0;
    end else if (bus.flush) begin
      // Flush wins over a completing fill so a half-written line never turns valid.
      state_reg <= IDLE;
      ren_reg   <= 1'b0;
      busy_reg  <= 1'b0;
      valid_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.imemREN && !hit) begin
            state_reg   <= FILL;
            ren_reg     <= 1'b1;
            busy_reg    <= 1'b1;
            ltag_reg    <= req_tag;
            lidx_reg    <= IDX_W'(req_idx);
            cnt_reg     <= '0;
            vic_reg     <= vic_next;
            use_ptr_reg <= !free_found;
          end
        end
        FILL: begin
          if (!bus.iwait) begin
            cnt_reg <= cnt_reg + 1'b1;
            if (last_word) begin
              state_reg <= IDLE;
              ren_reg   <= 1'b0;
              busy_reg  <= 1'b0;
              valid_reg[line_index(int'(lidx_reg), int'(vic_reg))] <= 1'b1;
              if (use_ptr_reg)
                ptr_reg[lidx_reg] <= WBV'((int'(ptr_reg[lidx_reg]) + 1) % WAYS);
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (state_reg == FILL && !bus.iwait && !bus.flush) begin
      data_mem[word_index(int'(lidx_reg), int'(vic_reg), int'(cnt_reg))] <= bus.iload;
      if (last_word)
        tag_mem[line_index(int'(lidx_reg), int'(vic_reg))] <= ltag_reg;
    end
  end

endmodule
